// File: rtl/rvb_bmat_pkg.sv
// Shared decode constants and tag layout for the bmator/bmatxor issue stage.
package rvb_bmat_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [2:0] F3_BMAT    = 3'b011;
  localparam logic [6:0] F7_BMATOR  = 7'b0000100;
  localparam logic [6:0] F7_BMATXOR = 7'b0100100;

  localparam int unsigned TAG_W = 6;

  // One in-flight instruction: destination index plus "retire as illegal" flag.
  typedef struct packed {
    logic [4:0] rd;
    logic       ill;
  } tag_t;

  // True for bmator/bmatxor only; bmatflip and everything else is rejected.
  function automatic logic is_bmat(input logic [31:0] insn);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = insn[6:0];
    f3  = insn[14:12];
    f7  = insn[31:25];
    return (opc == OPC_OP) && (f3 == F3_BMAT) &&
           ((f7 == F7_BMATOR) || (f7 == F7_BMATXOR));
  endfunction

endpackage

// File: rtl/rvb_bmat_tagfifo.sv
// In-order tag FIFO holding {rd, ill} for every accepted instruction.
module rvb_bmat_tagfifo
  import rvb_bmat_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  tag_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvb_bmat_issue.sv
// Issue/retire stage in front of the bmator/bmatxor unit: decode, operand issue, in-order writeback.
module rvb_bmat_issue
  import rvb_bmat_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            unit_valid,
  input  logic            unit_ready,
  output logic [XLEN-1:0] unit_rs1,
  output logic [XLEN-1:0] unit_rs2,
  output logic            unit_insn30,
  input  logic            unit_rvalid,
  output logic            unit_rready,
  input  logic [XLEN-1:0] unit_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_idx,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal,
  output logic            busy
);

  logic legal;
  logic accept;
  logic pop;
  logic run;
  logic fifo_full;
  logic fifo_empty;
  tag_t in_tag;
  tag_t head;

  assign legal    = is_bmat(in_insn);
  assign in_tag   = '{rd: in_insn[11:7], ill: !legal};
  assign in_ready = run && !fifo_full && (!unit_valid || unit_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;
  assign busy     = !fifo_empty || unit_valid;

  rvb_bmat_tagfifo #(
    .DEPTH (DEPTH)
  ) u_tagfifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (accept),
    .push_tag (in_tag),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) run <= 1'b0;
    else         run <= 1'b1;
  end

  // Issue register: operands held stable until the unit takes them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      unit_valid  <= 1'b0;
      unit_rs1    <= '0;
      unit_rs2    <= '0;
      unit_insn30 <= 1'b0;
    end else if (accept && legal) begin
      unit_valid  <= 1'b1;
      unit_rs1    <= in_rs1;
      unit_rs2    <= in_rs2;
      unit_insn30 <= in_insn[30];
    end else if (unit_valid && unit_ready) begin
      unit_valid  <= 1'b0;
    end
  end

  // Retire from the FIFO head; illegal tags complete locally, legal ones wait on the unit.
  always_comb begin
    wb_valid    = 1'b0;
    wb_data     = '0;
    wb_illegal  = 1'b0;
    unit_rready = 1'b0;
    wb_rd_idx   = head.rd;
    if (!fifo_empty) begin
      if (head.ill) begin
        wb_valid   = 1'b1;
        wb_illegal = 1'b1;
      end else begin
        wb_valid    = unit_rvalid;
        wb_data     = unit_rd;
        unit_rready = wb_ready;
      end
    end
  end

  // A unit result with no legal tag waiting is a protocol error and is dropped.
  a_no_orphan_result: assert property (@(posedge clock) disable iff (!resetn)
    unit_rvalid |-> (!fifo_empty && !head.ill));

endmodule
